// File: rtl/pq_trial_div_filter.sv
// Trial-division filter between the p/q candidate FIFO and the primality-test FIFO.
// Pops one candidate and shifts it MSB first through per-prime remainder
// accumulators for the small odd primes {3,5,7,11,13,17,19,23}. It drops the
// candidate if it is even or has a zero remainder, and otherwise pushes it downstream.
// Ports:
//   aclk, areset                  clock, synchronous active-high reset
//   pq_fifo_dout/_empty/_rd_en    upstream FIFO read side (data valid the cycle after rd_en)
//   cand_fifo_din/_wr_en/_full    downstream FIFO write side
//   cnt_pass, cnt_reject          wrapping 32-bit outcome counters
//   busy                          high whenever the FSM is outside IDLE
module pq_trial_div_filter #(
  parameter int unsigned NUM_BITS   = 128,
  parameter int unsigned NUM_PRIMES = 8
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [NUM_BITS-1:0] pq_fifo_dout,
  input  logic                pq_fifo_empty,
  output logic                pq_fifo_rd_en,
  output logic [NUM_BITS-1:0] cand_fifo_din,
  output logic                cand_fifo_wr_en,
  input  logic                cand_fifo_full,
  output logic [31:0]         cnt_pass,
  output logic [31:0]         cnt_reject,
  output logic                busy
);

  localparam int unsigned CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int unsigned REM_W = 5;

  typedef enum logic [2:0] {IDLE, RD, LATCH, SCAN, DECIDE, WRITE} state_t;

  state_t                              state_q;
  logic [NUM_BITS-1:0]                 shift_q;
  logic [NUM_BITS-1:0]                 held_q;
  logic [CNT_W-1:0]                    bit_cnt_q;
  logic [NUM_PRIMES-1:0][REM_W-1:0]    rem_q;
  logic [NUM_PRIMES-1:0][REM_W-1:0]    rem_d;
  logic [NUM_PRIMES-1:0][REM_W:0]      t_c;
  logic [NUM_PRIMES-1:0]               rem_zero_c;
  logic                                rd_en_q;
  logic                                wr_en_q;
  logic                                busy_q;
  logic [NUM_BITS-1:0]                 din_q;
  logic [31:0]                         pass_q;
  logic [31:0]                         rej_q;

  // Table of small odd primes; index i selects the i-th entry.
  function automatic logic [REM_W-1:0] prime_at(input int unsigned idx);
    case (idx)
      0:       return REM_W'(3);
      1:       return REM_W'(5);
      2:       return REM_W'(7);
      3:       return REM_W'(11);
      4:       return REM_W'(13);
      5:       return REM_W'(17);
      6:       return REM_W'(19);
      default: return REM_W'(23);
    endcase
  endfunction

  // One remainder step per prime: r' = (2r+b) mod p. Because r < p, 2r+b < 2p,
  // so a single conditional subtraction is enough.
  always_comb begin
    rem_d      = rem_q;
    t_c        = '0;
    rem_zero_c = '0;
    for (int unsigned i = 0; i < NUM_PRIMES; i++) begin
      t_c[i]        = {rem_q[i], shift_q[NUM_BITS-1]};
      rem_d[i]      = (t_c[i] >= {1'b0, prime_at(i)})
                      ? REM_W'(t_c[i] - {1'b0, prime_at(i)})
                      : t_c[i][REM_W-1:0];
      rem_zero_c[i] = (rem_q[i] == '0);
    end
  end

  // Control FSM with the datapath registers and registered outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      held_q    <= '0;
      bit_cnt_q <= '0;
      rem_q     <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      din_q     <= '0;
      pass_q    <= '0;
      rej_q     <= '0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!pq_fifo_empty) begin
            state_q <= RD;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        RD: state_q <= LATCH;
        LATCH: begin
          shift_q   <= pq_fifo_dout;
          held_q    <= pq_fifo_dout;
          rem_q     <= '0;
          bit_cnt_q <= CNT_W'(NUM_BITS - 1);
          state_q   <= SCAN;
        end
        SCAN: begin
          rem_q   <= rem_d;
          shift_q <= shift_q << 1;
          if (bit_cnt_q == '0) begin
            state_q <= DECIDE;
          end else begin
            bit_cnt_q <= bit_cnt_q - CNT_W'(1);
          end
        end
        DECIDE: begin
          // Even candidates and multiples of any active table prime are dropped.
          if (!held_q[0] || (|rem_zero_c)) begin
            rej_q   <= rej_q + 32'd1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (!cand_fifo_full) begin
            din_q   <= held_q;
            wr_en_q <= 1'b1;
            pass_q  <= pass_q + 32'd1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pq_fifo_rd_en   = rd_en_q;
  assign cand_fifo_din   = din_q;
  assign cand_fifo_wr_en = wr_en_q;
  assign cnt_pass        = pass_q;
  assign cnt_reject      = rej_q;
  assign busy            = busy_q;

endmodule
